// File: rtl/br_flow_xbar_return.sv
// Return path of the flow-controlled crossbar: per-target tag FIFOs steer each
// target's response back to the source that issued the request, with per-source round-robin.
module br_flow_xbar_return #(
    parameter  int NumSources         = 2,
    parameter  int NumTargets         = 2,
    parameter  int Width              = 1,
    parameter  int TagDepth           = 4,
    parameter  int RegisterPopOutputs = 0,
    localparam int SrcIdWidth         = $clog2(NumSources)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NumTargets-1:0]                 tag_push_valid_i,
    output logic [NumTargets-1:0]                 tag_push_ready_o,
    input  logic [NumTargets-1:0][SrcIdWidth-1:0] tag_push_src_i,
    input  logic [NumTargets-1:0]                 resp_push_valid_i,
    output logic [NumTargets-1:0]                 resp_push_ready_o,
    input  logic [NumTargets-1:0][Width-1:0]      resp_push_data_i,
    output logic [NumSources-1:0]                 resp_pop_valid_o,
    input  logic [NumSources-1:0]                 resp_pop_ready_i,
    output logic [NumSources-1:0][Width-1:0]      resp_pop_data_o
);

    localparam int PtrW = (TagDepth > 1) ? $clog2(TagDepth) : 1;
    localparam int CntW = $clog2(TagDepth + 1);
    localparam int TgtW = $clog2(NumTargets);

    logic [NumTargets-1:0][TagDepth-1:0][SrcIdWidth-1:0] tag_mem_q;
    logic [NumTargets-1:0][PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [NumTargets-1:0][PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [NumTargets-1:0][CntW-1:0]       count_q, count_d;
    logic [NumTargets-1:0][SrcIdWidth-1:0] head;
    logic [NumTargets-1:0]                 nonempty;
    logic [NumTargets-1:0]                 tag_wr;
    logic [NumTargets-1:0]                 tag_rd;

    logic [NumSources-1:0][NumTargets-1:0] req;
    logic [NumSources-1:0][NumTargets-1:0] grant;
    logic [NumSources-1:0][TgtW-1:0]       prio_q, prio_d;
    logic [NumSources-1:0]                 any_req;
    logic [NumSources-1:0]                 sink_ready;
    logic [NumSources-1:0]                 xfer;
    logic [NumSources-1:0][Width-1:0]      sel_data;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(TagDepth - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    // Full means not ready, even if the head is being popped in the same cycle.
    always_comb begin
        nonempty         = '0;
        tag_push_ready_o = '0;
        tag_wr           = '0;
        tag_rd           = '0;
        head             = '0;
        for (int j = 0; j < NumTargets; j++) begin
            nonempty[j]         = (count_q[j] != '0);
            tag_push_ready_o[j] = (count_q[j] != CntW'(TagDepth));
            tag_wr[j]           = tag_push_valid_i[j] && tag_push_ready_o[j];
            tag_rd[j]           = resp_push_valid_i[j] && resp_push_ready_o[j];
            head[j]             = tag_mem_q[j][rd_ptr_q[j]];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int j = 0; j < NumTargets; j++) begin
            if (tag_wr[j]) begin
                wr_ptr_d[j] = ptr_inc(wr_ptr_q[j]);
            end
            if (tag_rd[j]) begin
                rd_ptr_d[j] = ptr_inc(rd_ptr_q[j]);
            end
            if (tag_wr[j] && !tag_rd[j]) begin
                count_d[j] = count_q[j] + CntW'(1);
            end else if (!tag_wr[j] && tag_rd[j]) begin
                count_d[j] = count_q[j] - CntW'(1);
            end
        end
    end

    always_comb begin
        req = '0;
        for (int s = 0; s < NumSources; s++) begin
            for (int j = 0; j < NumTargets; j++) begin
                req[s][j] = resp_push_valid_i[j] && nonempty[j] &&
                            (head[j] == SrcIdWidth'(s));
            end
        end
    end

    // Search starts at prio_q, the target just after the last one that transferred.
    always_comb begin
        logic found;
        int   idx;
        grant    = '0;
        any_req  = '0;
        sel_data = '0;
        found    = 1'b0;
        idx      = 0;
        for (int s = 0; s < NumSources; s++) begin
            found = 1'b0;
            for (int i = 0; i < NumTargets; i++) begin
                idx = int'(prio_q[s]) + i;
                if (idx >= NumTargets) begin
                    idx = idx - NumTargets;
                end
                if (!found && req[s][idx]) begin
                    grant[s][idx] = 1'b1;
                    found         = 1'b1;
                end
            end
            any_req[s] = |req[s];
            for (int j = 0; j < NumTargets; j++) begin
                sel_data[s] = sel_data[s] | (resp_push_data_i[j] & {Width{grant[s][j]}});
            end
        end
    end

    always_comb begin
        resp_push_ready_o = '0;
        xfer              = '0;
        prio_d            = prio_q;
        for (int s = 0; s < NumSources; s++) begin
            xfer[s] = any_req[s] && sink_ready[s];
            for (int j = 0; j < NumTargets; j++) begin
                if (grant[s][j] && sink_ready[s]) begin
                    resp_push_ready_o[j] = 1'b1;
                end
                if (xfer[s] && grant[s][j]) begin
                    prio_d[s] = (j == NumTargets - 1) ? '0 : TgtW'(j + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            prio_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            prio_q   <= prio_d;
        end
    end

    // Tag storage needs no reset: entries are only read while the count is non-zero.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NumTargets; j++) begin
            if (tag_wr[j]) begin
                tag_mem_q[j][wr_ptr_q[j]] <= tag_push_src_i[j];
            end
        end
    end

    if (RegisterPopOutputs != 0) begin : g_reg_pop
        logic [NumSources-1:0]            pop_valid_q;
        logic [NumSources-1:0][Width-1:0] pop_data_q;

        always_comb begin
            sink_ready = ~pop_valid_q | resp_pop_ready_i;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pop_valid_q <= '0;
                pop_data_q  <= '0;
            end else begin
                for (int s = 0; s < NumSources; s++) begin
                    if (sink_ready[s]) begin
                        pop_valid_q[s] <= any_req[s];
                        if (any_req[s]) begin
                            pop_data_q[s] <= sel_data[s];
                        end
                    end
                end
            end
        end

        assign resp_pop_valid_o = pop_valid_q;
        assign resp_pop_data_o  = pop_data_q;
    end else begin : g_comb_pop
        assign sink_ready       = resp_pop_ready_i;
        assign resp_pop_valid_o = any_req;
        assign resp_pop_data_o  = sel_data;
    end

    // A response with no outstanding tag has nowhere to go and is held off.
    for (genvar j = 0; j < NumTargets; j++) begin : g_chk
        assert property (@(posedge clk) disable iff (!rst_n)
                         !(resp_push_valid_i[j] && (count_q[j] == '0)))
        else $warning("br_flow_xbar_return: response on target %0d with no outstanding tag is held", j);
    end

endmodule
